// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC job sequencer.
// Holds the FSM state enum, load-pipeline latencies and a FIFO depth helper.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } mac_seq_state_t;

    // Cycles from a FIFO read strobe to the operand and result loads.
    localparam int LD_OP_LAT  = 1;
    localparam int LD_RES_LAT = 2;

    function automatic int depth(input int addr_lines);
        return 1 << addr_lines;
    endfunction

endpackage

// File: rtl/mac_ld_pipe.sv
// Fixed-latency load pipeline: turns the FIFO read strobe into datapath loads.
// Ports: clk_i, rstn_i, i_rd (read strobe), o_ld_op, o_ld_res, o_pipe_empty.
module mac_ld_pipe
    import mac_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_rd,
    output logic o_ld_op,
    output logic o_ld_res,
    output logic o_pipe_empty
);

    logic [LD_RES_LAT-1:0] r_vld;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LD_RES_LAT-2:0], i_rd};
        end
    end

    assign o_ld_op  = r_vld[LD_OP_LAT-1];
    assign o_ld_res = r_vld[LD_RES_LAT-1];

    // Only the last stage may still be set: its LD_result fires this cycle,
    // so nothing remains in flight once the clock edge passes.
    assign o_pipe_empty = ~|r_vld[LD_RES_LAT-2:0];

endmodule

// File: rtl/mac_sequencer.sv
// Job-level controller for the MAC block: fill FIFOs, clear, run N taps, done.
// Ports: start/taps/keep job request, upstream valid/ready, FIFO flags in,
//        FIFO enables, datapath loads, rst_reg_n/redo clears, busy/done out.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [ADDR_LINES:0]   taps_i,
    input  logic                  keep_coeff_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  full_sig_i,
    input  logic                  empty_sig_i,
    input  logic                  full_coeff_i,
    input  logic                  empty_coeff_i,
    output logic                  wr_en_signal,
    output logic                  wr_en_coeff,
    output logic                  rd_en_signal,
    output logic                  rd_en_coeff,
    output logic                  LD_signal,
    output logic                  LD_coeff,
    output logic                  LD_result,
    output logic                  rst_reg_n,
    output logic                  redo,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = ADDR_LINES + 1;
    localparam logic [CW-1:0] MAX_TAPS = CW'(depth(ADDR_LINES));

    if (DATA_WIDTH < 1 || ADDR_LINES < 1) begin : g_bad_param
        $error("mac_sequencer: DATA_WIDTH and ADDR_LINES must be >= 1");
    end

    mac_seq_state_t r_state;
    mac_seq_state_t w_next;

    logic [CW-1:0] r_taps;
    logic          r_keep;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;

    logic [CW-1:0] w_taps;
    logic [CW-1:0] w_wr_nxt;
    logic [CW-1:0] w_rd_nxt;
    logic          w_pipe_empty;

    // Out-of-range tap requests are clamped to the FIFO depth.
    assign w_taps   = (taps_i > MAX_TAPS) ? MAX_TAPS : taps_i;
    assign w_wr_nxt = r_wr_cnt + CW'(1);
    assign w_rd_nxt = r_rd_cnt + CW'(1);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state  <= ST_IDLE;
            r_taps   <= '0;
            r_keep   <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start_i) begin
                r_taps   <= w_taps;
                r_keep   <= keep_coeff_i;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (wr_en_signal) r_wr_cnt <= w_wr_nxt;
                if (rd_en_signal) r_rd_cnt <= w_rd_nxt;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        in_ready_o   = 1'b0;
        wr_en_signal = 1'b0;
        wr_en_coeff  = 1'b0;
        rd_en_signal = 1'b0;
        rd_en_coeff  = 1'b0;
        rst_reg_n    = 1'b1;
        redo         = 1'b0;
        done_o       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Fresh job clears the accumulator; a reuse job rewinds the
                // coefficient pointer instead. Never both in one cycle.
                rst_reg_n = r_keep;
                redo      = r_keep;
                w_next    = (r_taps == '0) ? ST_DONE : ST_FILL;
            end
            ST_FILL: begin
                in_ready_o   = (r_wr_cnt < r_taps) & ~full_sig_i
                             & (r_keep | ~full_coeff_i);
                wr_en_signal = in_valid_i & in_ready_o;
                wr_en_coeff  = in_valid_i & in_ready_o & ~r_keep;
                if (wr_en_signal && w_wr_nxt == r_taps) w_next = ST_RUN;
            end
            ST_RUN: begin
                rd_en_signal = (r_rd_cnt < r_taps) & ~empty_sig_i
                             & ~empty_coeff_i;
                rd_en_coeff  = rd_en_signal;
                if (rd_en_signal && w_rd_nxt == r_taps) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pipe_empty) w_next = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (r_state != ST_IDLE);

    mac_ld_pipe u_ld_pipe (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .i_rd         (rd_en_signal),
        .o_ld_op      (LD_signal),
        .o_ld_res     (LD_result),
        .o_pipe_empty (w_pipe_empty)
    );

    assign LD_coeff = LD_signal;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural FIFO/datapath model.
// Each task runs one scenario and compares against hand-computed values.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic       start_i = 1'b0;
    logic [4:0] taps_i = '0;
    logic       keep_coeff_i = 1'b0;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       full_sig_i, empty_sig_i, full_coeff_i, empty_coeff_i;
    logic       wr_en_signal, wr_en_coeff, rd_en_signal, rd_en_coeff;
    logic       LD_signal, LD_coeff, LD_result;
    logic       rst_reg_n, redo, busy_o, done_o;

    logic f_full = 1'b0;
    logic f_empty = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    int src_sig [0:63];
    int src_coef[0:63];
    int src_len = 0;
    int src_idx = 0;

    int sig_mem[0:15];
    int coef_mem[0:15];
    int s_wp = 0, s_rp = 0, c_wp = 0, c_rp = 0, c_base = 0;
    int s_dout = 0, c_dout = 0, sig_reg = 0, coef_reg = 0, acc = 0;

    int lat;
    int cnt_ld, cnt_wrs, cnt_wrc, cnt_rstlow, cnt_redo, cnt_rdy_f, cnt_en;
    logic [63:0] rd_mask, ld_mask;

    logic [11:0] w_outs;

    always #5 clk = ~clk;

    mac_sequencer #(.DATA_WIDTH(32), .ADDR_LINES(4)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .start_i       (start_i),
        .taps_i        (taps_i),
        .keep_coeff_i  (keep_coeff_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .full_sig_i    (full_sig_i),
        .empty_sig_i   (empty_sig_i),
        .full_coeff_i  (full_coeff_i),
        .empty_coeff_i (empty_coeff_i),
        .wr_en_signal  (wr_en_signal),
        .wr_en_coeff   (wr_en_coeff),
        .rd_en_signal  (rd_en_signal),
        .rd_en_coeff   (rd_en_coeff),
        .LD_signal     (LD_signal),
        .LD_coeff      (LD_coeff),
        .LD_result     (LD_result),
        .rst_reg_n     (rst_reg_n),
        .redo          (redo),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    assign in_valid_i    = (src_idx < src_len);
    assign full_sig_i    = (s_wp - s_rp == 16) | f_full;
    assign empty_sig_i   = (s_wp == s_rp) | f_empty;
    assign full_coeff_i  = (c_wp - c_rp == 16);
    assign empty_coeff_i = (c_wp == c_rp);

    assign w_outs = {in_ready_o, wr_en_signal, wr_en_coeff, rd_en_signal,
                     rd_en_coeff, LD_signal, LD_coeff, LD_result, redo,
                     busy_o, done_o, rst_reg_n};

    // Behavioural MAC block: two FIFOs (coeff FIFO rewindable) and datapath.
    always @(posedge clk) begin
        if (in_valid_i && in_ready_o) src_idx <= src_idx + 1;
        if (!rstn_i) begin
            s_wp <= 0; s_rp <= 0; c_wp <= 0; c_rp <= 0; c_base <= 0;
            sig_reg <= 0; coef_reg <= 0; acc <= 0;
        end else begin
            if (wr_en_signal) begin
                sig_mem[s_wp % 16] <= src_sig[src_idx];
                s_wp <= s_wp + 1;
            end
            if (wr_en_coeff) begin
                if (c_wp == c_rp) c_base <= c_wp;
                coef_mem[c_wp % 16] <= src_coef[src_idx];
                c_wp <= c_wp + 1;
            end
            if (rd_en_signal) begin
                s_dout <= sig_mem[s_rp % 16];
                s_rp <= s_rp + 1;
            end
            if (redo) begin
                c_rp <= c_base;
            end else if (rd_en_coeff) begin
                c_dout <= coef_mem[c_rp % 16];
                c_rp <= c_rp + 1;
            end
            if ((!rst_reg_n) ^ redo) begin
                sig_reg <= 0; coef_reg <= 0; acc <= 0;
            end else begin
                if (LD_signal) sig_reg <= s_dout;
                if (LD_coeff) coef_reg <= c_dout;
                if (LD_result) acc <= acc + sig_reg * coef_reg;
            end
        end
    end

    task automatic push(input int s, input int c);
        src_sig[src_len] = s;
        src_coef[src_len] = c;
        src_len = src_len + 1;
    endtask

    // Starts a job and steps until done_o (bounded). lat counts edges since
    // start_i was raised; ff/fe windows force full_sig/empty_sig high.
    task automatic run_job(input int n, input bit keep,
                           input int ff_at, input int ff_len,
                           input int fe_at, input int fe_len,
                           input int bs_at);
        cnt_ld = 0; cnt_wrs = 0; cnt_wrc = 0; cnt_rstlow = 0;
        cnt_redo = 0; cnt_rdy_f = 0; cnt_en = 0;
        rd_mask = '0; ld_mask = '0;
        lat = 0;
        start_i = 1'b1;
        taps_i = 5'(n);
        keep_coeff_i = keep;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start_i = (lat == bs_at);
            if (lat == bs_at) taps_i = 5'd7;
            f_full  = (lat >= ff_at) && (lat < ff_at + ff_len);
            f_empty = (lat >= fe_at) && (lat < fe_at + fe_len);
            #1;
            if (LD_result) cnt_ld++;
            if (wr_en_signal) cnt_wrs++;
            if (wr_en_coeff) cnt_wrc++;
            if (!rst_reg_n) cnt_rstlow++;
            if (redo) cnt_redo++;
            if (f_full && in_ready_o) cnt_rdy_f++;
            if (wr_en_signal | wr_en_coeff | rd_en_signal | rd_en_coeff |
                LD_signal | LD_coeff | LD_result) cnt_en++;
            if (lat < 64) begin
                if (rd_en_signal) rd_mask[lat] = 1'b1;
                if (LD_result) ld_mask[lat] = 1'b1;
            end
        end while (!done_o && lat < 200);
        start_i = 1'b0;
        f_full = 1'b0;
        f_empty = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (w_outs !== 12'h001)
            $display("FAIL reset_outs: got %h want %h", w_outs, 12'h001);
        else n_pass++;
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0)
            $display("FAIL reset_idle_busy: got %b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_fresh();
        push(1, 5); push(2, 6); push(3, 7); push(4, 8);
        run_job(4, 1'b0, 0, 0, 0, 0, -1);
        n_checks++;
        if (lat !== 12) $display("FAIL fresh_lat: got %0d want 12", lat);
        else n_pass++;
        n_checks++;
        if (acc !== 70) $display("FAIL fresh_result: got %0d want 70", acc);
        else n_pass++;
        n_checks++;
        if (cnt_ld !== 4) $display("FAIL fresh_ld_cnt: got %0d want 4", cnt_ld);
        else n_pass++;
        n_checks++;
        if (cnt_rstlow !== 1)
            $display("FAIL fresh_rst_low: got %0d want 1", cnt_rstlow);
        else n_pass++;
        n_checks++;
        if (cnt_redo !== 0) $display("FAIL fresh_redo: got %0d want 0", cnt_redo);
        else n_pass++;
    endtask

    task automatic test_keep();
        for (int i = 0; i < 4; i++) push(2, 0);
        run_job(4, 1'b1, 0, 0, 0, 0, -1);
        n_checks++;
        if (cnt_redo !== 1) $display("FAIL keep_redo: got %0d want 1", cnt_redo);
        else n_pass++;
        n_checks++;
        if (cnt_rstlow !== 0)
            $display("FAIL keep_rst_low: got %0d want 0", cnt_rstlow);
        else n_pass++;
        n_checks++;
        if (cnt_wrc !== 0) $display("FAIL keep_wr_coeff: got %0d want 0", cnt_wrc);
        else n_pass++;
        n_checks++;
        if (acc !== 52) $display("FAIL keep_result: got %0d want 52", acc);
        else n_pass++;
        n_checks++;
        if (lat !== 12) $display("FAIL keep_lat: got %0d want 12", lat);
        else n_pass++;
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 16; i++) push(i + 1, 16 - i);
        run_job(16, 1'b0, 6, 3, 0, 0, -1);
        n_checks++;
        if (lat !== 39) $display("FAIL full_lat: got %0d want 39", lat);
        else n_pass++;
        n_checks++;
        if (cnt_rdy_f !== 0)
            $display("FAIL full_ready_forced: got %0d want 0", cnt_rdy_f);
        else n_pass++;
        n_checks++;
        if (cnt_wrs !== 16) $display("FAIL full_wr_cnt: got %0d want 16", cnt_wrs);
        else n_pass++;
        n_checks++;
        if (cnt_ld !== 16) $display("FAIL full_ld_cnt: got %0d want 16", cnt_ld);
        else n_pass++;
        n_checks++;
        if (acc !== 816) $display("FAIL full_result: got %0d want 816", acc);
        else n_pass++;
    endtask

    task automatic test_empty_stall();
        push(1, 5); push(2, 6); push(3, 7); push(4, 8);
        run_job(4, 1'b0, 0, 0, 7, 2, -1);
        n_checks++;
        if (rd_mask !== 64'hE40)
            $display("FAIL empty_rd_mask: got %h want %h", rd_mask, 64'hE40);
        else n_pass++;
        n_checks++;
        if (ld_mask !== 64'h3900)
            $display("FAIL empty_ld_mask: got %h want %h", ld_mask, 64'h3900);
        else n_pass++;
        n_checks++;
        if (acc !== 70) $display("FAIL empty_result: got %0d want 70", acc);
        else n_pass++;
        n_checks++;
        if (lat !== 14) $display("FAIL empty_lat: got %0d want 14", lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        push(9, 9); push(9, 9); push(9, 9); push(9, 9);
        start_i = 1'b1;
        taps_i = 5'd4;
        keep_coeff_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy_o);
        else n_pass++;
        rstn_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (w_outs !== 12'h001)
            $display("FAIL mid_reset_outs: got %h want %h", w_outs, 12'h001);
        else n_pass++;
        rstn_i = 1'b1;
        push(3, 4); push(5, 6);
        run_job(2, 1'b0, 0, 0, 0, 0, 3);
        n_checks++;
        if (lat !== 8) $display("FAIL mid_lat: got %0d want 8", lat);
        else n_pass++;
        n_checks++;
        if (acc !== 42) $display("FAIL mid_result: got %0d want 42", acc);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0)
            $display("FAIL busy_start_ignored: got %b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_zero_taps();
        run_job(0, 1'b0, 0, 0, 0, 0, -1);
        n_checks++;
        if (lat !== 2) $display("FAIL zero_lat: got %0d want 2", lat);
        else n_pass++;
        n_checks++;
        if (cnt_en !== 0) $display("FAIL zero_enables: got %0d want 0", cnt_en);
        else n_pass++;
        n_checks++;
        if (cnt_ld !== 0) $display("FAIL zero_ld_cnt: got %0d want 0", cnt_ld);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fresh();
        repeat (2) @(posedge clk);
        #1;
        test_keep();
        repeat (2) @(posedge clk);
        #1;
        test_full_stall();
        repeat (2) @(posedge clk);
        #1;
        test_empty_stall();
        repeat (2) @(posedge clk);
        #1;
        test_reset_mid();
        test_zero_taps();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
